// File: rtl/inst_fetch_pkg.sv
// Shared CPU defines used by the fetch stage: FSM encodings, reset vector and pc helper.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-read bus between the fetch stage (master) and the memory controller (slave).
interface inst_fetch_if;
    logic        inst_en_o;
    logic [31:0] inst_addr_o;
    logic        inst_rdy_i;
    logic [31:0] inst_inst_i;

    modport master (
        output inst_en_o,
        output inst_addr_o,
        input  inst_rdy_i,
        input  inst_inst_i
    );

    modport slave (
        input  inst_en_o,
        input  inst_addr_o,
        output inst_rdy_i,
        output inst_inst_i
    );
endinterface

// File: rtl/inst_fetch_icache_array.sv
// Direct-mapped single-word-line instruction cache storage: combinational lookup, synchronous fill.
module icache_array #(
    parameter int IDX_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:2]   rd_addr_i,
    output logic          hit_o,
    output logic [31:0]   rd_data_o,
    input  logic          wr_en_i,
    input  logic [31:2]   wr_addr_i,
    input  logic [31:0]   wr_data_i
);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int LINES = 1 << IDX_W;

    logic [TAG_W-1:0] tag_q   [LINES];
    logic [31:0]      data_q  [LINES];
    logic [LINES-1:0] valid_q;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;

    assign rd_idx    = rd_addr_i[IDX_W+1:2];
    assign rd_tag    = rd_addr_i[31:IDX_W+2];
    assign wr_idx    = wr_addr_i[IDX_W+1:2];
    assign wr_tag    = wr_addr_i[31:IDX_W+2];
    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data_o = data_q[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data_i;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: icache lookup, one instruction per cycle on hits, blocking refill on misses.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IDX_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush_i,
    input  logic [31:0]       flush_pc_i,
    input  logic              stall_i,
    output logic              if_valid_o,
    output logic [31:0]       if_pc_o,
    output logic [31:0]       if_inst_o,
    inst_fetch_if.master      mem
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  miss_addr_q, miss_addr_d;
    logic         inst_en_q, inst_en_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;

    logic         hit;
    logic [31:0]  line_data;
    logic         slot_free;
    logic         fill;

    assign slot_free = !if_valid_q || !stall_i;
    // A returning word is always written, even when a flush has made it useless to present.
    assign fill      = rdy && mem.inst_rdy_i && (state_q != FETCH);

    icache_array #(.IDX_W(IDX_W)) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (pc_q[31:2]),
        .hit_o     (hit),
        .rd_data_o (line_data),
        .wr_en_i   (fill),
        .wr_addr_i (miss_addr_q[31:2]),
        .wr_data_i (mem.inst_inst_i)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        miss_addr_d = miss_addr_q;
        inst_en_d   = inst_en_q;
        if_valid_d  = if_valid_q && stall_i;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;

        if (flush_i) begin
            pc_d       = flush_pc_i;
            if_valid_d = 1'b0;
            case (state_q)
                MISS:    state_d = mem.inst_rdy_i ? FETCH : DRAIN;
                DRAIN:   state_d = mem.inst_rdy_i ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
            if (state_q != FETCH && mem.inst_rdy_i) begin
                inst_en_d = 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (slot_free && hit) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_inst_d  = line_data;
                        pc_d       = pc_next(pc_q);
                    end else if (slot_free) begin
                        miss_addr_d = pc_q;
                        inst_en_d   = 1'b1;
                        state_d     = MISS;
                    end
                end
                MISS, DRAIN: begin
                    if (mem.inst_rdy_i) begin
                        inst_en_d = 1'b0;
                        state_d   = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            miss_addr_q <= 32'h0;
            inst_en_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'h0;
            if_inst_q   <= 32'h0;
        end else if (rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            miss_addr_q <= miss_addr_d;
            inst_en_q   <= inst_en_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
        end
    end

    assign if_valid_o      = if_valid_q;
    assign if_pc_o         = if_pc_q;
    assign if_inst_o       = if_inst_q;
    assign mem.inst_en_o   = inst_en_q;
    assign mem.inst_addr_o = inst_en_q ? miss_addr_q : 32'h0;
endmodule
